// File: rtl/io_port.sv
// Memory-mapped I/O port at CPU address 0: stores feed an outbound FIFO,
// loads drain an inbound FIFO, with sticky overflow/underflow flags.
module io_port #(
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   input  logic        we,
   input  logic        rd_en,
   output logic [15:0] io_word,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        tx_full,
   output logic        rx_empty,
   output logic        overflow,
   output logic        underflow
);

   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned TX_CW = TX_AW + 1;
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned RX_CW = RX_AW + 1;

   logic [15:0]      tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr;
   logic [TX_AW-1:0] tx_rd;
   logic [TX_CW-1:0] tx_cnt;

   logic [15:0]      rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr;
   logic [RX_AW-1:0] rx_rd;
   logic [RX_CW-1:0] rx_cnt;

   logic sel;
   logic tx_push;
   logic tx_pop;
   logic tx_drop;
   logic rx_push;
   logic rx_pop;
   logic rx_under;

   // Status derived from the occupancy counts
   assign sel      = (addr == 16'h0000);
   assign tx_valid = (tx_cnt != '0);
   assign tx_full  = (tx_cnt == TX_CW'(TX_DEPTH));
   assign rx_empty = (rx_cnt == '0);
   assign rx_ready = (rx_cnt != RX_CW'(RX_DEPTH));

   // Handshake qualifiers; a full FIFO refuses a push even when popping
   assign tx_push  = we & sel & ~tx_full;
   assign tx_drop  = we & sel & tx_full;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = rd_en & sel & ~rx_empty;
   assign rx_under = rd_en & sel & rx_empty;

   // Head words presented to the sink and to the CPU
   assign tx_data = tx_mem[tx_rd];
   assign io_word = rx_empty ? 16'h0000 : rx_mem[rx_rd];

   // TX storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= data;
   end

   // RX storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr] <= rx_data;
   end

   // TX pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
         if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
            2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // RX pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr  <= '0;
         rx_rd  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
         if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
            2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (tx_drop)  overflow  <= 1'b1;
         if (rx_under) underflow <= 1'b1;
      end
   end

endmodule
